// File: rtl/mem_fifo_ctrl_256_64_pkg.sv
// ---------------------------------------------------------------------------
// mem_fifo_pkg
// Shared constants and types for the memory-backed FIFO controller.
//   DEPTH/WIDTH     : external memory geometry (entries x bits)
//   AW/LW           : address width and level width (level spans 0..DEPTH+2)
//   AFULL_THRESH    : default almost_full threshold
//   ob_occ_t        : occupancy of the 2-entry output buffer
// ---------------------------------------------------------------------------
package mem_fifo_pkg;

    localparam int DEPTH        = 256;
    localparam int WIDTH        = 64;
    localparam int AW           = 8;
    localparam int LW           = 9;
    localparam int AFULL_THRESH = 240;

    typedef enum logic [1:0] {
        OB_EMPTY = 2'd0,
        OB_ONE   = 2'd1,
        OB_TWO   = 2'd2
    } ob_occ_t;

    // Number of words held by the output buffer as a plain count.
    function automatic logic [1:0] ob_count(input ob_occ_t occ);
        logic [1:0] n;
        n = occ;
        return n;
    endfunction

endpackage

// File: rtl/mem_fifo_ctrl_256_64_if.sv
// ---------------------------------------------------------------------------
// mem_fifo_ctrl_256_64_if
// Bundles the producer stream, consumer stream and the external memory ports
// of the FIFO controller.
//   in_valid/in_ready/in_data      : producer handshake
//   out_valid/out_ready/out_data   : consumer handshake
//   mem_we/mem_waddr/mem_wdata     : memory write port
//   mem_re/mem_raddr/mem_rdata     : memory read port (rdata one clk after re)
// Modports:
//   slave  : the controller
//   master : the environment (producer, consumer and memory)
// ---------------------------------------------------------------------------
interface mem_fifo_ctrl_256_64_if
    import mem_fifo_pkg::*;
;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    logic             mem_re;
    logic [AW-1:0]    mem_raddr;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  in_valid, in_data, out_ready, mem_rdata,
        output in_ready, out_valid, out_data,
               mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
    );

    modport master (
        output in_valid, in_data, out_ready, mem_rdata,
        input  in_ready, out_valid, out_data,
               mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
    );

endinterface

// File: rtl/mem_fifo_ctrl_256_64_outbuf.sv
// ---------------------------------------------------------------------------
// mem_fifo_outbuf
// Two-entry output buffer sitting behind the external memory read port.
// A read returning this cycle (cap_valid) is presented straight to the
// consumer when the buffer is empty, so a word issued at T+1 is visible at
// T+2; otherwise it is captured at the end of the cycle.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   cap_valid, cap_data : memory read data valid this cycle
//   out_ready           : consumer accepts
//   out_valid, out_data : oldest word available
//   occ                 : number of words registered in the buffer
//
// state    | meaning
// ---------+-------------------------------------------
// OB_EMPTY | no registered word (may bypass cap_data)
// OB_ONE   | ent0 holds the oldest word
// OB_TWO   | ent0 oldest, ent1 next
// ---------------------------------------------------------------------------
module mem_fifo_outbuf #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cap_valid,
    input  logic [WIDTH-1:0]     cap_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output mem_fifo_pkg::ob_occ_t occ
);
    import mem_fifo_pkg::*;

    ob_occ_t          occ_q, occ_d;
    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic             pop;

    assign out_valid = (occ_q != OB_EMPTY) || cap_valid;
    // ent0 resets to zero, so an idle buffer shows out_data = 0.
    assign out_data  = ((occ_q == OB_EMPTY) && cap_valid) ? cap_data : ent0_q;
    assign pop       = out_valid && out_ready;
    assign occ       = occ_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q  <= OB_EMPTY;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            occ_q  <= occ_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
        end
    end

    always_comb begin
        occ_d  = occ_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        case (occ_q)
            OB_EMPTY: begin
                // Capture with simultaneous pop is a pure bypass.
                if (cap_valid && !pop) begin
                    ent0_d = cap_data;
                    occ_d  = OB_ONE;
                end
            end
            OB_ONE: begin
                if (cap_valid && pop) begin
                    ent0_d = cap_data;
                end else if (cap_valid) begin
                    ent1_d = cap_data;
                    occ_d  = OB_TWO;
                end else if (pop) begin
                    occ_d  = OB_EMPTY;
                end
            end
            OB_TWO: begin
                if (pop) begin
                    ent0_d = ent1_q;
                    if (cap_valid) begin
                        ent1_d = cap_data;
                    end else begin
                        occ_d  = OB_ONE;
                    end
                end
            end
            default: begin
                occ_d = OB_EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/mem_fifo_ctrl_256_64.sv
// ---------------------------------------------------------------------------
// mem_fifo_ctrl_256_64
// FIFO controller around an external single-clock 256 x 64 memory with a
// one-cycle read latency. Words are written straight into memory, read back
// as soon as buffer space allows and presented through a 2-entry output
// buffer, giving T+2 latency and one word per cycle sustained.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (slave)  : producer/consumer handshakes and memory read/write ports
//   level        : total words held (memory + in flight + buffered), 0..258
//   almost_full  : level >= AFULL_THRESH
// Build option:
//   MEM_FIFO_CTRL_LEVEL_EN defined   -> level/almost_full tracked
//   MEM_FIFO_CTRL_LEVEL_EN undefined -> level/almost_full tied to 0
// ---------------------------------------------------------------------------
module mem_fifo_ctrl_256_64 #(
    parameter int DEPTH        = 256,
    parameter int WIDTH        = 64,
    parameter int AFULL_THRESH = 240
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mem_fifo_ctrl_256_64_if.slave      bus,
    output logic [mem_fifo_pkg::LW-1:0] level,
    output logic                       almost_full
);
    import mem_fifo_pkg::*;

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] mem_cnt;
    logic          inflight;
    ob_occ_t       ob_occ;

    logic          wr_fire;
    logic          rd_pop;
    logic          rd_issue;
    logic [1:0]    held_after_pop;

    // in_ready looks only at registered occupancy: no path from out_ready.
    assign bus.in_ready  = (mem_cnt != LW'(DEPTH));
    assign wr_fire       = bus.in_valid && bus.in_ready;

    assign bus.mem_we    = wr_fire;
    assign bus.mem_waddr = wptr;
    assign bus.mem_wdata = bus.in_data;

    assign rd_pop = bus.out_valid && bus.out_ready;

    // Words that will sit in the buffer path after this edge. Counting the
    // current pop lets a pop from a full controller refill immediately, so
    // in_ready rises on the very next cycle. A pop always implies at least
    // one held word, so this cannot underflow.
    assign held_after_pop = ob_count(ob_occ) + {1'b0, inflight} - {1'b0, rd_pop};

    // mem_cnt only counts words written on earlier edges, so the read
    // address can never equal the write address of the current cycle.
    assign rd_issue      = (mem_cnt != '0) && (held_after_pop < 2'd2);
    assign bus.mem_re    = rd_issue;
    assign bus.mem_raddr = rptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (wr_fire) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_issue) begin
                rptr <= rptr + AW'(1);
            end
            case ({wr_fire, rd_issue})
                2'b10:   mem_cnt <= mem_cnt + LW'(1);
                2'b01:   mem_cnt <= mem_cnt - LW'(1);
                default: mem_cnt <= mem_cnt;
            endcase
            inflight <= rd_issue;
        end
    end

    // A read in flight across reset is dropped because inflight clears,
    // so the stale mem_rdata of the next cycle is never captured.
    mem_fifo_outbuf #(
        .WIDTH (WIDTH)
    ) u_outbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_valid (inflight),
        .cap_data  (bus.mem_rdata),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .occ       (ob_occ)
    );

`ifdef MEM_FIFO_CTRL_LEVEL_EN
    logic [LW-1:0] level_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            case ({wr_fire, rd_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign level       = level_q;
    assign almost_full = (level_q >= LW'(AFULL_THRESH));
`else
    assign level       = '0;
    assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl_256_64.sv
// ---------------------------------------------------------------------------
// tb_mem_fifo_ctrl_256_64
// Self-checking bench for mem_fifo_ctrl_256_64 with a behavioural memory and
// a scoreboard queue of accepted words.
// ---------------------------------------------------------------------------
module tb_mem_fifo_ctrl_256_64;

    localparam logic [63:0] FILL_BASE = 64'h1000_0000_0000_0000;
    localparam logic [63:0] STRM_BASE = 64'h2000_0000_0000_0000;
    localparam logic [63:0] RST_BASE  = 64'h3000_0000_0000_0000;
    localparam logic [63:0] SINGLE_W  = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] POST_RST  = 64'hFEED_FACE_0000_0042;

    logic       clk;
    logic       rst_n;
    logic [8:0] level;
    logic       almost_full;

    mem_fifo_ctrl_256_64_if bus();

    mem_fifo_ctrl_256_64 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .level       (level),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External memory: synchronous write, read data one clk after mem_re.
    logic [63:0] mem_model [256];
    always @(posedge clk) begin
        if (bus.mem_we) mem_model[bus.mem_waddr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem_model[bus.mem_raddr];
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_coll   = 0;
    logic [63:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lvl_exp(input int v);
`ifdef MEM_FIFO_CTRL_LEVEL_EN
        return 64'(v);
`else
        return 64'd0 + 64'(v * 0);
`endif
    endfunction

    function automatic logic [63:0] af_exp(input int v);
`ifdef MEM_FIFO_CTRL_LEVEL_EN
        return (v >= 240) ? 64'd1 : 64'd0;
`else
        return 64'd0 + 64'(v * 0);
`endif
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (bus.mem_re && bus.mem_we && (bus.mem_raddr == bus.mem_waddr)) n_coll++;
            if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) chk("sb_data", bus.out_data, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int cyc;
        int sent;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset held for three edges.
        repeat (3) tick();
        @(negedge clk);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_level",     64'(level),         64'd0);
        chk("rst_afull",     64'(almost_full),   64'd0);
        chk("rst_mem_we",    64'(bus.mem_we),    64'd0);
        chk("rst_mem_re",    64'(bus.mem_re),    64'd0);
        chk("rst_out_data",  bus.out_data,       64'd0);
        chk("rst_waddr",     64'(bus.mem_waddr), 64'd0);

        // Single word, out_ready held high.
        tick();
        rst_n         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = SINGLE_W;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t0_mem_we",  64'(bus.mem_we),    64'd1);
        chk("t0_waddr",   64'(bus.mem_waddr), 64'd0);
        chk("t0_no_re",   64'(bus.mem_re),    64'd0);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t1_mem_re",    64'(bus.mem_re),    64'd1);
        chk("t1_raddr",     64'(bus.mem_raddr), 64'd0);
        chk("t1_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t1_level",     64'(level),         lvl_exp(1));
        @(negedge clk);
        chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t2_out_data",  bus.out_data,       SINGLE_W);
        @(negedge clk);
        chk("t3_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t3_level",     64'(level),         lvl_exp(0));

        // Fill with the consumer stalled.
        acc = 0;
        cyc = 0;
        while (acc < 258 && cyc < 400) begin
            tick();
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_data   = FILL_BASE + 64'(acc);
            @(negedge clk);
            chk("fill_level",    64'(level),        lvl_exp(acc));
            chk("fill_afull",    64'(almost_full),  af_exp(acc));
            chk("fill_in_ready", 64'(bus.in_ready), 64'd1);
            if (bus.in_ready) acc++;
            cyc++;
        end
        chk("fill_count", 64'(acc), 64'd258);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready",  64'(bus.in_ready),  64'd0);
        chk("full_level",     64'(level),         lvl_exp(258));
        chk("full_afull",     64'(almost_full),   af_exp(258));
        chk("full_out_valid", 64'(bus.out_valid), 64'd1);

        // One pop while full; a write attempt that cycle must be refused.
        tick();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        chk("pop_full_same_cycle", 64'(bus.in_ready), 64'd0);
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        chk("pop_full_next_cycle", 64'(bus.in_ready), 64'd1);
        chk("pop_full_level",      64'(level),        lvl_exp(257));

        // Random stream across pointer wrap.
        sent = 0;
        cyc  = 0;
        while (sent < 600 && cyc < 20000) begin
            tick();
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = STRM_BASE + 64'(sent);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) sent++;
            cyc++;
        end
        chk("stream_sent", 64'(sent), 64'd600);

        // Drain everything.
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc = 0;
        @(negedge clk);
        #1;
        while ((sb.size() != 0 || bus.out_valid) && cyc < 2000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("drain_sb_empty",  64'(sb.size()),     64'd0);
        chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
        chk("drain_level",     64'(level),         lvl_exp(0));
        chk("no_collision",    64'(n_coll),        64'd0);

        // Reset mid-stream with level 100 and a read in flight.
        acc = 0;
        cyc = 0;
        while (acc < 100 && cyc < 200) begin
            tick();
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_data   = RST_BASE + 64'(acc);
            @(negedge clk);
            if (bus.in_ready) acc++;
            cyc++;
        end
        chk("rst_fill_count", 64'(acc), 64'd100);
        tick();
        bus.in_valid  = 1'b1;
        bus.in_data   = RST_BASE + 64'd100;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("mid_read_issued", 64'(bus.mem_re), 64'd1);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        chk("mid_level",     64'(level),         lvl_exp(100));
        chk("mid_out_valid", 64'(bus.out_valid), 64'd1);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("post_rst_level",     64'(level),         64'd0);
        chk("post_rst_in_ready",  64'(bus.in_ready),  64'd1);
        tick();
        @(negedge clk);
        chk("stale_rdata_ignored", 64'(bus.out_valid), 64'd0);
        tick();
        bus.in_valid  = 1'b1;
        bus.in_data   = POST_RST;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!bus.out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("post_rst_valid", 64'(bus.out_valid), 64'd1);
        chk("post_rst_first", bus.out_data,       POST_RST);
        repeat (3) @(negedge clk);
        chk("end_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_fifo_ctrl_256_64.md
MEM_FIFO_CTRL_256_64 -- requirements
Module: mem_fifo_ctrl_256_64

Interface
REQ-001 Parameter DEPTH, 256: number of memory entries.
REQ-002 Parameter WIDTH, 64: data width in bits.
REQ-003 Parameter AFULL_THRESH, 240: level at or above which almost_full is asserted.
REQ-004 clk  input  1  single clock; the external memory's wclk and rclk are both tied to clk.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 in_valid  input  1  producer has a word.
REQ-007 in_ready  output  1  controller accepts a word.
REQ-008 in_data  input  64  write word.
REQ-009 out_valid  output  1  out_data holds a word.
REQ-010 out_ready  input  1  consumer accepts a word.
REQ-011 out_data  output  64  oldest word held.
REQ-012 mem_we, mem_waddr[7:0], mem_wdata[63:0]  output  memory write port.
REQ-013 mem_re, mem_raddr[7:0]  output  memory read port.
REQ-014 mem_rdata  input  64  memory read data, valid one clk after mem_re.
REQ-015 level  output  9  total words held, range 0..258.
REQ-016 almost_full  output  1  level >= AFULL_THRESH.

Function
REQ-017 Accept: a write is accepted when in_valid && in_ready; a read completes when out_valid && out_ready.
REQ-018 Write path: an accepted write drives mem_we=1, mem_waddr=wptr and mem_wdata=in_data combinationally in the same cycle; wptr then increments mod 256.
REQ-019 Memory occupancy: mem_cnt (0..256) counts words in memory that have not yet been read.
REQ-020 in_ready: in_ready = (mem_cnt != 256), derived from registered state only, with no combinational path from out_ready.
REQ-021 Read issue: mem_re=1 and mem_raddr=rptr when mem_cnt>0 and (buffered words + in-flight reads) < 2; rptr then increments mod 256.
REQ-022 Read return: mem_rdata is captured into a 2-entry output buffer one cycle after mem_re.
REQ-023 Output: out_valid=1 whenever the output buffer is non-empty; out_data is the oldest buffered word, held stable while out_valid && !out_ready.
REQ-024 Ordering: words leave in strict FIFO order.
REQ-025 Latency: a word written into an empty controller at cycle T presents out_valid at T+2.
REQ-026 Throughput: with in_valid=out_ready=1 continuously, one word per cycle sustained.
REQ-027 Collision-free: mem_re never targets the address written in the same cycle, because a read is issued only for entries written in earlier cycles.
REQ-028 Full: at mem_cnt=256 with the buffer holding 2 words, level=258 and in_ready=0.
REQ-029 Full with simultaneous read: an out handshake when full raises in_ready on the following cycle, never the same cycle.
REQ-030 Wrap: wptr and rptr wrap 255->0 without loss of data.
REQ-031 Empty with simultaneous write: a write into an empty controller in the same cycle as an idle read produces no mem_re that cycle.

Reset
REQ-032 While rst_n=0 at a clk edge: wptr, rptr, mem_cnt, in-flight flag and buffer occupancy clear to 0, and all held data is discarded.
REQ-033 Reset values: in_ready=1, out_valid=0, mem_we=0, mem_re=0, level=0, almost_full=0, address outputs 0, out_data 0.
REQ-034 Reset mid-operation: a read in flight at reset is dropped, and its mem_rdata is ignored in the following cycle.

Configuration
REQ-035 Macro MEM_FIFO_CTRL_LEVEL_EN defined: level and almost_full are computed as specified above.
REQ-036 Macro MEM_FIFO_CTRL_LEVEL_EN undefined: the level and almost_full ports remain present but are tied to 0, and the level counter is not synthesized.

Structure
REQ-037 Shared package mem_fifo_pkg holds DEPTH, WIDTH, AW=8, LW=9 and the output-buffer occupancy type.
REQ-038 Sub-module mem_fifo_outbuf implements the 2-entry output buffer: capture, pop and occupancy count.

Verification
REQ-039 Reset check: hold rst_n=0 for 3 cycles -> in_ready=1, out_valid=0, level=0, mem_we=mem_re=0.
REQ-040 Single word: write 64'hDEAD_BEEF_0000_0001 at cycle T with out_ready=1 -> mem_re at T+1, out_valid with that data at T+2, level returns to 0 at T+3.
REQ-041 Fill with out_ready=0: 258 writes accepted -> in_ready=0 after the 258th, level=258, almost_full=1 from level 240.
REQ-042 Drain when full: one pop -> in_ready=1 on the next cycle; then stream 600 incrementing words with random in_valid/out_ready -> order preserved across pointer wrap, no mem_re address equal to mem_waddr in any cycle.
REQ-043 Reset mid-stream: assert rst_n=0 with level=100 and a read in flight -> next cycle out_valid=0, level=0; the first word written afterwards is output first.
REQ-044 Build without MEM_FIFO_CTRL_LEVEL_EN: repeat the REQ-041 scenario -> level=0, almost_full=0, FIFO data unchanged.
